// File: rtl/mips_sopc_if.sv
// Instruction fetch bus between the core and the instruction ROM.
//   pc   : byte address of the instruction being fetched (core -> ROM)
//   ce   : fetch enable; the ROM returns a nop while it is low (core -> ROM)
//   inst : instruction word at pc (ROM -> core, combinational)
interface mips_sopc_if;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] inst;

  modport master (output pc, output ce, input inst);
  modport slave  (input pc, input ce, output inst);
endinterface

// File: rtl/mips_sopc.sv
// Minimal SOPC: 5-stage MIPS32 integer core (IF/ID/EX/MEM/WB) plus a
// word-addressed instruction ROM. The ROM contents are loaded from outside
// (hierarchical writes to rom.storage); results live in cpu.register.storage
// and in the HI/LO registers of cpu.stage_wb.
// Ports of mips_sopc:
//   clock : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset of all core state

// Combinational-read instruction ROM; returns a nop when fetch is disabled.
module mips_rom #(
  parameter int ROM_DEPTH = 1024
) (
  mips_sopc_if.slave rom_bus
);
  localparam int AW = $clog2(ROM_DEPTH);

  logic [31:0] storage [0:ROM_DEPTH-1];
  logic        unused_pc_bits;

  assign rom_bus.inst   = rom_bus.ce ? storage[rom_bus.pc[AW+1:2]] : 32'h0;
  assign unused_pc_bits = ^{rom_bus.pc[31:AW+2], rom_bus.pc[1:0]};
endmodule

// 32 x 32 register file: two combinational read ports, one write port.
// A read of the register being written this cycle returns the new value.
module mips_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr [2],
  output logic [31:0] rdata [2]
);
  logic [31:0] storage [0:31];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) storage[i] <= 32'h0;
    end else if (we && waddr != 5'd0) begin
      storage[waddr] <= wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        if (raddr[gi] == 5'd0)
          rdata[gi] = 32'h0;
        else if (we && waddr == raddr[gi])
          rdata[gi] = wdata;
        else
          rdata[gi] = storage[raddr[gi]];
      end
    end
  endgenerate
endmodule

// Write-back stage HI/LO registers.
module mips_stage_wb (
  input  logic        clock,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_data,
  input  logic [31:0] lo_data,
  output logic [31:0] register_hi_read_data,
  output logic [31:0] register_lo_read_data
);
  logic [31:0] hi_reg, lo_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_reg <= 32'h0;
      lo_reg <= 32'h0;
    end else begin
      if (hi_we) hi_reg <= hi_data;
      if (lo_we) lo_reg <= lo_data;
    end
  end

  assign register_hi_read_data = hi_reg;
  assign register_lo_read_data = lo_reg;
endmodule

module mips_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic         clock,
  input logic         reset,
  mips_sopc_if.master rom_bus
);
  typedef enum logic [3:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT,
    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } alu_op_t;

  // Everything a finished instruction may write back.
  typedef struct packed {
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_t;

  // ---------------- IF ----------------
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic [31:0] if_id_inst_reg;

  // First edge out of reset only enables fetch; pc advances afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg <= RESET_PC;
      ce_reg <= 1'b0;
    end else if (!ce_reg) begin
      ce_reg <= 1'b1;
    end else begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  assign rom_bus.pc = pc_reg;
  assign rom_bus.ce = ce_reg;

  always_ff @(posedge clock) begin
    if (reset) if_id_inst_reg <= 32'h0;
    else       if_id_inst_reg <= rom_bus.inst;
  end

  // ---------------- ID ----------------
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [4:0]  rf_raddr [2];
  logic [31:0] rf_rdata [2];
  logic [31:0] rs_val, rt_val;
  alu_op_t     id_op;
  logic [31:0] id_a, id_b;
  logic        id_wreg;
  logic [4:0]  id_waddr;

  wb_t ex_out, ex_mem_reg, mem_wb_reg;

  assign opcode = if_id_inst_reg[31:26];
  assign rs     = if_id_inst_reg[25:21];
  assign rt     = if_id_inst_reg[20:16];
  assign rd     = if_id_inst_reg[15:11];
  assign shamt  = if_id_inst_reg[10:6];
  assign funct  = if_id_inst_reg[5:0];
  assign imm    = if_id_inst_reg[15:0];

  assign rf_raddr[0] = rs;
  assign rf_raddr[1] = rt;

  // Newest value wins: EX result, then MEM, then the register file (which
  // already bypasses the WB write). $0 is never forwarded.
  always_comb begin
    rs_val = rf_rdata[0];
    rt_val = rf_rdata[1];
    if (rs != 5'd0 && ex_mem_reg.wreg && ex_mem_reg.waddr == rs) rs_val = ex_mem_reg.wdata;
    if (rs != 5'd0 && ex_out.wreg && ex_out.waddr == rs)         rs_val = ex_out.wdata;
    if (rt != 5'd0 && ex_mem_reg.wreg && ex_mem_reg.waddr == rt) rt_val = ex_mem_reg.wdata;
    if (rt != 5'd0 && ex_out.wreg && ex_out.waddr == rt)         rt_val = ex_out.wdata;
  end

  // Shifts carry the shift amount in operand a and the value in operand b.
  always_comb begin
    id_op    = OP_NOP;
    id_a     = rs_val;
    id_b     = rt_val;
    id_wreg  = 1'b0;
    id_waddr = rt;
    case (opcode)
      6'h00: begin
        id_wreg  = 1'b1;
        id_waddr = rd;
        case (funct)
          6'h24: id_op = OP_AND;
          6'h25: id_op = OP_OR;
          6'h26: id_op = OP_XOR;
          6'h27: id_op = OP_NOR;
          6'h21: id_op = OP_ADD;
          6'h23: id_op = OP_SUB;
          6'h2a: id_op = OP_SLT;
          6'h2b: id_op = OP_SLTU;
          6'h00: begin id_op = OP_SLL; id_a = {27'h0, shamt}; end
          6'h02: begin id_op = OP_SRL; id_a = {27'h0, shamt}; end
          6'h03: begin id_op = OP_SRA; id_a = {27'h0, shamt}; end
          6'h04: id_op = OP_SLL;
          6'h06: id_op = OP_SRL;
          6'h07: id_op = OP_SRA;
          6'h10: id_op = OP_MFHI;
          6'h12: id_op = OP_MFLO;
          6'h11: begin id_op = OP_MTHI; id_wreg = 1'b0; end
          6'h13: begin id_op = OP_MTLO; id_wreg = 1'b0; end
          default: id_wreg = 1'b0;
        endcase
      end
      6'h0c: begin id_op = OP_AND;  id_b = {16'h0, imm};           id_wreg = 1'b1; end
      6'h0d: begin id_op = OP_OR;   id_b = {16'h0, imm};           id_wreg = 1'b1; end
      6'h0e: begin id_op = OP_XOR;  id_b = {16'h0, imm};           id_wreg = 1'b1; end
      6'h09: begin id_op = OP_ADD;  id_b = {{16{imm[15]}}, imm};   id_wreg = 1'b1; end
      6'h0a: begin id_op = OP_SLT;  id_b = {{16{imm[15]}}, imm};   id_wreg = 1'b1; end
      6'h0b: begin id_op = OP_SLTU; id_b = {{16{imm[15]}}, imm};   id_wreg = 1'b1; end
      6'h0f: begin id_op = OP_OR;   id_a = 32'h0; id_b = {imm, 16'h0}; id_wreg = 1'b1; end
      default: ;
    endcase
  end

  alu_op_t     id_ex_op_reg;
  logic [31:0] id_ex_a_reg, id_ex_b_reg;
  logic        id_ex_wreg_reg;
  logic [4:0]  id_ex_waddr_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      id_ex_op_reg    <= OP_NOP;
      id_ex_a_reg     <= 32'h0;
      id_ex_b_reg     <= 32'h0;
      id_ex_wreg_reg  <= 1'b0;
      id_ex_waddr_reg <= 5'd0;
    end else begin
      id_ex_op_reg    <= id_op;
      id_ex_a_reg     <= id_a;
      id_ex_b_reg     <= id_b;
      id_ex_wreg_reg  <= id_wreg;
      id_ex_waddr_reg <= id_waddr;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] hi_cur, lo_cur, hi_fwd, lo_fwd;

  // Pending mthi/mtlo further down the pipe override the committed HI/LO.
  always_comb begin
    hi_fwd = hi_cur;
    lo_fwd = lo_cur;
    if (mem_wb_reg.hi_we) hi_fwd = mem_wb_reg.hi;
    if (mem_wb_reg.lo_we) lo_fwd = mem_wb_reg.lo;
    if (ex_mem_reg.hi_we) hi_fwd = ex_mem_reg.hi;
    if (ex_mem_reg.lo_we) lo_fwd = ex_mem_reg.lo;
  end

  always_comb begin
    ex_out       = '0;
    ex_out.wreg  = id_ex_wreg_reg;
    ex_out.waddr = id_ex_waddr_reg;
    case (id_ex_op_reg)
      OP_AND:  ex_out.wdata = id_ex_a_reg & id_ex_b_reg;
      OP_OR:   ex_out.wdata = id_ex_a_reg | id_ex_b_reg;
      OP_XOR:  ex_out.wdata = id_ex_a_reg ^ id_ex_b_reg;
      OP_NOR:  ex_out.wdata = ~(id_ex_a_reg | id_ex_b_reg);
      OP_ADD:  ex_out.wdata = id_ex_a_reg + id_ex_b_reg;
      OP_SUB:  ex_out.wdata = id_ex_a_reg - id_ex_b_reg;
      OP_SLT:  ex_out.wdata = {31'h0, $signed(id_ex_a_reg) < $signed(id_ex_b_reg)};
      OP_SLTU: ex_out.wdata = {31'h0, id_ex_a_reg < id_ex_b_reg};
      OP_SLL:  ex_out.wdata = id_ex_b_reg << id_ex_a_reg[4:0];
      OP_SRL:  ex_out.wdata = id_ex_b_reg >> id_ex_a_reg[4:0];
      OP_SRA:  ex_out.wdata = $unsigned($signed(id_ex_b_reg) >>> id_ex_a_reg[4:0]);
      OP_MFHI: ex_out.wdata = hi_fwd;
      OP_MFLO: ex_out.wdata = lo_fwd;
      OP_MTHI: begin ex_out.hi_we = 1'b1; ex_out.hi = id_ex_a_reg; end
      OP_MTLO: begin ex_out.lo_we = 1'b1; ex_out.lo = id_ex_a_reg; end
      default: ex_out.wreg = 1'b0;
    endcase
  end

  // ---------------- MEM (pass-through) / WB ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      ex_mem_reg <= ex_out;
      mem_wb_reg <= ex_mem_reg;
    end
  end

  mips_regfile register (
    .clock (clock),
    .reset (reset),
    .we    (mem_wb_reg.wreg),
    .waddr (mem_wb_reg.waddr),
    .wdata (mem_wb_reg.wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  mips_stage_wb stage_wb (
    .clock                 (clock),
    .reset                 (reset),
    .hi_we                 (mem_wb_reg.hi_we),
    .lo_we                 (mem_wb_reg.lo_we),
    .hi_data               (mem_wb_reg.hi),
    .lo_data               (mem_wb_reg.lo),
    .register_hi_read_data (hi_cur),
    .register_lo_read_data (lo_cur)
  );
endmodule

module mips_sopc #(
  parameter int          ROM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clock,
  input logic reset
);
  mips_sopc_if rom_bus ();

  mips_cpu #(.RESET_PC(RESET_PC)) cpu (
    .clock   (clock),
    .reset   (reset),
    .rom_bus (rom_bus)
  );

  mips_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
    .rom_bus (rom_bus)
  );
endmodule

// File: tb/tb_mips_sopc.sv
module tb_mips_sopc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  mips_sopc dut (
    .clock (clock),
    .reset (reset)
  );

  // Mirror of the fetch bus for observation.
  mips_sopc_if probe_if ();
  assign probe_if.pc   = dut.rom_bus.pc;
  assign probe_if.ce   = dut.rom_bus.ce;
  assign probe_if.inst = dut.rom_bus.inst;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) begin
      $display("[TB] check %s observed=%08h expected=%08h ok", tag, observed, expected);
    end else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 1024; i++) dut.rom.storage[i] = 32'h0;
  endtask

  task automatic rom_word(input int idx, input logic [31:0] w);
    dut.rom.storage[idx] = w;
  endtask

  function automatic logic [31:0] gpr(input int idx);
    return dut.cpu.register.storage[idx];
  endfunction

  function automatic logic [31:0] hi_now();
    return dut.cpu.stage_wb.register_hi_read_data;
  endfunction

  function automatic logic [31:0] lo_now();
    return dut.cpu.stage_wb.register_lo_read_data;
  endfunction

  // Apply one reset edge with the new program loaded, then release.
  task automatic restart();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    // ---- ROM fetch / basic write timing ----
    rom_clear();
    rom_word(0, 32'h34011100);  // ori $1,$0,0x1100
    rom_word(1, 32'h34020020);  // ori $2,$0,0x0020
    tick(2);
    check("rst_pc", probe_if.pc, 32'h0);
    check("rst_ce", {31'h0, probe_if.ce}, 32'h0);
    check("rst_r1", gpr(1), 32'h0);
    check("rst_hi", hi_now(), 32'h0);
    check("rst_inst_nop", probe_if.inst, 32'h0);
    reset = 1'b0;
    tick(1);
    check("e1_ce", {31'h0, probe_if.ce}, 32'h1);
    check("e1_pc", probe_if.pc, 32'h0);
    tick(1);
    check("e2_pc", probe_if.pc, 32'h4);
    tick(3);
    check("e5_r1_not_yet", gpr(1), 32'h0);
    tick(1);
    check("e6_r1", gpr(1), 32'h00001100);
    check("e6_r2_not_yet", gpr(2), 32'h0);
    tick(1);
    check("e7_r2", gpr(2), 32'h00000020);

    // ---- forwarding chain ----
    reset = 1'b1;
    rom_clear();
    rom_word(0, 32'h34011100);  // ori $1,$0,0x1100
    rom_word(1, 32'h34210020);  // ori $1,$1,0x0020
    rom_word(2, 32'h34214400);  // ori $1,$1,0x4400
    rom_word(3, 32'h34210044);  // ori $1,$1,0x0044
    restart();
    tick(6);
    check("fwd_e6", gpr(1), 32'h00001100);
    tick(1);
    check("fwd_e7", gpr(1), 32'h00001120);
    tick(1);
    check("fwd_e8", gpr(1), 32'h00005520);
    tick(1);
    check("fwd_e9", gpr(1), 32'h00005564);

    // ---- logic, shift, arithmetic ----
    reset = 1'b1;
    rom_clear();
    rom_word(0, 32'h3C020404);  // lui  $2,0x0404
    rom_word(1, 32'h34420404);  // ori  $2,$2,0x0404
    rom_word(2, 32'h00021A00);  // sll  $3,$2,8
    rom_word(3, 32'h00032603);  // sra  $4,$3,24
    rom_word(4, 32'h2405FFFF);  // addiu $5,$0,-1
    rom_word(5, 32'h0005302B);  // sltu $6,$0,$5
    restart();
    tick(6);
    check("lui_r2", gpr(2), 32'h04040000);
    tick(5);
    check("ori_r2", gpr(2), 32'h04040404);
    check("sll_r3", gpr(3), 32'h04040400);
    check("sra_r4", gpr(4), 32'h00000004);
    check("addiu_r5", gpr(5), 32'hFFFFFFFF);
    check("sltu_r6", gpr(6), 32'h00000001);

    // ---- HI/LO back-to-back ----
    reset = 1'b1;
    rom_clear();
    rom_word(0, 32'h3401AAAA);  // ori  $1,$0,0xAAAA
    rom_word(1, 32'h00200011);  // mthi $1
    rom_word(2, 32'h00000013);  // mtlo $0
    rom_word(3, 32'h00001010);  // mfhi $2
    restart();
    tick(6);
    check("hilo_r1", gpr(1), 32'h0000AAAA);
    check("hilo_hi_before", hi_now(), 32'h0);
    tick(3);
    check("hilo_hi", hi_now(), 32'h0000AAAA);
    check("hilo_lo", lo_now(), 32'h0);
    check("hilo_mfhi_r2", gpr(2), 32'h0000AAAA);

    // ---- $0 protection ----
    reset = 1'b1;
    rom_clear();
    rom_word(0, 32'h34070055);  // ori $7,$0,0x0055
    rom_word(1, 32'h3400FFFF);  // ori $0,$0,0xFFFF
    rom_word(2, 32'h00003825);  // or  $7,$0,$0
    restart();
    tick(6);
    check("z_r7_set", gpr(7), 32'h00000055);
    tick(2);
    check("z_r0", gpr(0), 32'h0);
    check("z_r7_clear", gpr(7), 32'h0);

    // ---- reset mid-run, then identical re-execution ----
    reset = 1'b1;
    rom_clear();
    rom_word(0, 32'h3401AAAA);
    rom_word(1, 32'h00200011);
    rom_word(2, 32'h00000013);
    rom_word(3, 32'h00001010);
    restart();
    tick(8);
    check("mid_r1_before", gpr(1), 32'h0000AAAA);
    check("mid_hi_before", hi_now(), 32'h0000AAAA);
    reset = 1'b1;
    tick(1);
    check("mid_r1_rst", gpr(1), 32'h0);
    check("mid_hi_rst", hi_now(), 32'h0);
    check("mid_pc_rst", probe_if.pc, 32'h0);
    check("mid_ce_rst", {31'h0, probe_if.ce}, 32'h0);
    reset = 1'b0;
    tick(9);
    check("mid_r1_after", gpr(1), 32'h0000AAAA);
    check("mid_r2_after", gpr(2), 32'h0000AAAA);
    check("mid_hi_after", hi_now(), 32'h0000AAAA);
    check("mid_lo_after", lo_now(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
